// File: rtl/adc_input_axil_wr_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) for the adc_input register file.
interface adc_input_axil_wr_if;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/adc_input_axil_wr.sv
// AXI4-Lite write slave for the adc_input register file: held config words plus
// self-clearing command pulse bits in register 0.
//
// state   | meaning
// S_IDLE  | collecting AW and W independently; ready = !held
// S_WRITE | one cycle: decode held address, apply strobes, fire pulse/wr_stb
// S_RESP  | BVALID high, waiting for BREADY
module adc_input_axil_wr #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_PULSE_MASK = 32'h0000_0001
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  adc_input_axil_wr_if.slave        bus,
  output logic [32*C_NUM_REGS-1:0]  regs_o,
  output logic [31:0]               pulse_o,
  output logic [C_NUM_REGS-1:0]     wr_stb_o
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RESP} state_t;

  localparam logic [31:0] C_WIN = 32'(C_NUM_REGS * 4);

  state_t                state_q, state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic [31:0]           awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [31:0]           pulse_q, pulse_d;
  logic [C_NUM_REGS-1:0] wr_stb_q, wr_stb_d;
  logic [31:0]           regs_q [C_NUM_REGS];
  logic [31:0]           regs_d [C_NUM_REGS];

  logic                  aw_hs, w_hs, hit;
  logic [31:0]           off, bmask;

  assign aw_hs = awready_q & bus.AWVALID;
  assign w_hs  = wready_q & bus.WVALID;
  assign off   = awaddr_q - C_BASEADDR;
  // Full-offset window compare is equivalent to idx < C_NUM_REGS with off[1:0] ignored.
  assign hit   = (awaddr_q >= C_BASEADDR) && (off < C_WIN);
  assign bmask = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    wr_stb_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          awaddr_d  = bus.AWADDR;
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = bus.WDATA;
          wstrb_d  = bus.WSTRB;
          w_held_d = 1'b1;
        end
        if (aw_held_d && w_held_d) begin
          state_d   = S_WRITE;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      S_WRITE: begin
        state_d  = S_RESP;
        bvalid_d = 1'b1;
        bresp_d  = hit ? 2'b00 : 2'b10;
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (hit && off[31:2] == 30'(i)) begin
            regs_d[i]   = (regs_q[i] & ~bmask) | (wdata_q & bmask);
            wr_stb_d[i] = 1'b1;
          end
        end
        if (hit && off[31:2] == 30'd0)
          pulse_d = wdata_q & bmask & C_PULSE_MASK;
        regs_d[0] = regs_d[0] & ~C_PULSE_MASK;
      end
      S_RESP: begin
        if (bus.BREADY) begin
          state_d   = S_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      pulse_q   <= '0;
      wr_stb_q  <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      wr_stb_q  <= wr_stb_d;
      regs_q    <= regs_d;
    end
  end

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign pulse_o     = pulse_q;
  assign wr_stb_o    = wr_stb_q;

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_regs
    assign regs_o[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_adc_input_axil_wr.sv
// Bench for adc_input_axil_wr: a default instance and an 8-register instance with
// a two-bit pulse mask, driven through one shared stimulus path selected by sel.
module tb_adc_input_axil_wr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n;
  logic sel;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready;

  adc_input_axil_wr_if bus0 ();
  adc_input_axil_wr_if bus1 ();

  logic [127:0] regs0;
  logic [255:0] regs1;
  logic [31:0]  pulse0, pulse1;
  logic [3:0]   wr_stb0;
  logic [7:0]   wr_stb1;

  assign bus0.AWADDR  = awaddr;
  assign bus0.WDATA   = wdata;
  assign bus0.WSTRB   = wstrb;
  assign bus0.AWVALID = awvalid & ~sel;
  assign bus0.WVALID  = wvalid & ~sel;
  assign bus0.BREADY  = bready & ~sel;
  assign bus1.AWADDR  = awaddr;
  assign bus1.WDATA   = wdata;
  assign bus1.WSTRB   = wstrb;
  assign bus1.AWVALID = awvalid & sel;
  assign bus1.WVALID  = wvalid & sel;
  assign bus1.BREADY  = bready & sel;

  adc_input_axil_wr u_dut0 (
    .ACLK(clk), .ARESETN(rst0_n), .bus(bus0),
    .regs_o(regs0), .pulse_o(pulse0), .wr_stb_o(wr_stb0)
  );

  adc_input_axil_wr #(
    .C_BASEADDR(32'h0000_0100), .C_NUM_REGS(8), .C_PULSE_MASK(32'h8000_0001)
  ) u_dut1 (
    .ACLK(clk), .ARESETN(rst1_n), .bus(bus1),
    .regs_o(regs1), .pulse_o(pulse1), .wr_stb_o(wr_stb1)
  );

  wire        awready = sel ? bus1.AWREADY : bus0.AWREADY;
  wire        wready  = sel ? bus1.WREADY  : bus0.WREADY;
  wire        bvalid  = sel ? bus1.BVALID  : bus0.BVALID;
  wire [1:0]  bresp   = sel ? bus1.BRESP   : bus0.BRESP;
  wire [31:0] pulse   = sel ? pulse1 : pulse0;
  wire [7:0]  wr_stb  = sel ? wr_stb1 : {4'b0000, wr_stb0};

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  bresp;
    logic [7:0]  stb;
    logic [31:0] pulse;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m0 [4];
  logic [31:0] m1 [8];

  function automatic int nregs();
    return sel ? 8 : 4;
  endfunction

  function automatic logic [31:0] get_reg(input int i);
    return sel ? regs1[32*i +: 32] : regs0[32*i +: 32];
  endfunction

  function automatic logic [31:0] mreg(input int i);
    return sel ? m1[i] : m0[i];
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int w_lead, input int bready_low, input bit rst_in_write);
    exp_t e;
    logic [31:0] base, mask, off, bm, nv;
    bit hit, aw_done, w_done, aw_now, w_now;
    int idx, cyc;
    base = sel ? 32'h0000_0100 : 32'h0000_0000;
    mask = sel ? 32'h8000_0001 : 32'h0000_0001;
    off  = addr - base;
    hit  = (addr >= base) && (off < 32'(nregs() * 4));
    bm   = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    e.bresp = hit ? 2'b00 : 2'b10;
    e.stb   = '0;
    e.pulse = '0;
    if (hit) begin
      idx = int'(off[31:2]);
      e.stb[idx] = 1'b1;
      nv = (mreg(idx) & ~bm) | (data & bm);
      if (idx == 0) begin
        e.pulse = data & bm & mask;
        nv = nv & ~mask;
      end
      if (sel) m1[idx] = nv; else m0[idx] = nv;
    end
    exp_q.push_back(e);

    awaddr = addr; wdata = data; wstrb = strb;
    bready = (bready_low == 0);
    wvalid = 1'b1;
    awvalid = (w_lead == 0);
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      @(posedge clk); #1; cyc++;
      if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
      if (w_now)  begin wvalid  = 1'b0; w_done  = 1; end
      if (!aw_done && !awvalid && cyc >= w_lead) awvalid = 1'b1;
      if (w_done && !aw_done) begin
        checks++;
        if (wready !== 1'b0) begin
          errors++; $display("FAIL wready_while_held: got %b exp 0", wready);
        end
      end
    end
    checks++;
    if (!(aw_done && w_done)) begin
      errors++; $display("FAIL handshake_timeout: got aw=%0d w=%0d exp both done", aw_done, w_done);
      awvalid = 0; wvalid = 0;
      void'(exp_q.pop_back());
      return;
    end

    checks++;
    if ({awready, wready, bvalid} !== 3'b000) begin
      errors++; $display("FAIL write_cycle: got aw/w/b=%b exp 000", {awready, wready, bvalid});
    end

    if (rst_in_write) begin
      if (sel) rst1_n = 1'b0; else rst0_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      for (int i = 0; i < 8; i++) begin m0[i%4] = '0; m1[i] = '0; end
      checks++;
      if ({bvalid, pulse, wr_stb} !== 41'd0) begin
        errors++; $display("FAIL rst_mid_outputs: got bvalid=%b pulse=%h stb=%h exp 0", bvalid, pulse, wr_stb);
      end
      for (int i = 0; i < nregs(); i++) begin
        checks++;
        if (get_reg(i) !== 32'h0) begin
          errors++; $display("FAIL rst_mid_reg%0d: got %h exp 00000000", i, get_reg(i));
        end
      end
      @(posedge clk); @(posedge clk); #1;
      rst0_n = 1'b1; rst1_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({awready, wready, bvalid} !== 3'b110) begin
        errors++; $display("FAIL rst_mid_release: got aw/w/b=%b exp 110", {awready, wready, bvalid});
      end
      return;
    end

    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (bvalid !== 1'b1) begin
      errors++; $display("FAIL bvalid_k2: got %b exp 1", bvalid);
    end
    checks++;
    if (bresp !== e.bresp) begin
      errors++; $display("FAIL bresp: got %b exp %b", bresp, e.bresp);
    end
    checks++;
    if (wr_stb !== e.stb) begin
      errors++; $display("FAIL wr_stb: got %b exp %b", wr_stb, e.stb);
    end
    checks++;
    if (pulse !== e.pulse) begin
      errors++; $display("FAIL pulse: got %h exp %h", pulse, e.pulse);
    end
    for (int i = 0; i < nregs(); i++) begin
      checks++;
      if (get_reg(i) !== mreg(i)) begin
        errors++; $display("FAIL reg%0d: got %h exp %h", i, get_reg(i), mreg(i));
      end
    end

    for (int n = 1; n < bready_low; n++) begin
      @(posedge clk); #1;
      checks++;
      if ({bvalid, awready, wready} !== 3'b100 || pulse !== 32'h0 || wr_stb !== 8'h0 || bresp !== e.bresp) begin
        errors++;
        $display("FAIL resp_hold: got b/aw/w=%b pulse=%h stb=%h bresp=%b exp 100 0 0 %b",
                 {bvalid, awready, wready}, pulse, wr_stb, bresp, e.bresp);
      end
    end
    bready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011 || pulse !== 32'h0 || wr_stb !== 8'h0) begin
      errors++;
      $display("FAIL idle_after: got b/aw/w=%b pulse=%h stb=%h exp 011 0 0",
               {bvalid, awready, wready}, pulse, wr_stb);
    end
    bready = 1'b0;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst0_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      checks++;
      if ({awready, wready, bvalid, bresp} !== 5'b11000 || pulse !== 32'h0 || wr_stb !== 8'h0) begin
        errors++;
        $display("FAIL reset_outputs sel=%0d: got aw/w/b/resp=%b pulse=%h stb=%h exp 11000 0 0",
                 s, {awready, wready, bvalid, bresp}, pulse, wr_stb);
      end
      for (int i = 0; i < nregs(); i++) begin
        checks++;
        if (get_reg(i) !== 32'h0) begin
          errors++; $display("FAIL reset_reg%0d sel=%0d: got %h exp 00000000", i, s, get_reg(i));
        end
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_same_cycle();
    sel = 1'b0;
    wr(32'h4, 32'h0000_1000, 4'hF, 0, 0, 0);
    checks++;
    if (regs0[63:32] !== 32'h0000_1000) begin
      errors++; $display("FAIL same_cycle_reg1: got %h exp 00001000", regs0[63:32]);
    end
  endtask

  task automatic test_w_lead_pulse();
    sel = 1'b0;
    wr(32'h0, 32'h0000_0003, 4'hF, 3, 5, 0);
    checks++;
    if (regs0[31:0] !== 32'h0000_0002) begin
      errors++; $display("FAIL w_lead_reg0: got %h exp 00000002", regs0[31:0]);
    end
  endtask

  task automatic test_strobes();
    sel = 1'b0;
    wr(32'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    wr(32'h8, 32'h1234_5678, 4'b0101, 0, 1, 0);
    checks++;
    if (regs0[95:64] !== 32'hFF34_FF78) begin
      errors++; $display("FAIL strobe_reg2: got %h exp ff34ff78", regs0[95:64]);
    end
    wr(32'h8, 32'hDEAD_BEEF, 4'b0000, 0, 0, 0);
    wr(32'h0, 32'h0000_0001, 4'b0000, 0, 0, 0);
  endtask

  task automatic test_miss();
    sel = 1'b0;
    wr(32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    wr(32'hFFFF_FFFC, 32'hCAFE_F00D, 4'hF, 2, 2, 0);
    wr(32'h13, 32'h0000_0001, 4'hF, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    wr(32'h4, 32'h0000_0055, 4'hF, 0, 0, 1);
    wr(32'h4, 32'h0000_A5A5, 4'hF, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    wr(32'hC, 32'h0000_0011, 4'hF, 0, 0, 0);
    wr(32'hE, 32'h0000_2200, 4'b0010, 0, 0, 0);
    wr(32'h1, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
  endtask

  task automatic test_wide();
    sel = 1'b1;
    wr(32'h100, 32'h8000_0001, 4'hF, 0, 0, 0);
    checks++;
    if (regs1[31:0] !== 32'h0) begin
      errors++; $display("FAIL wide_reg0: got %h exp 00000000", regs1[31:0]);
    end
    wr(32'h11C, 32'h8000_0001, 4'hF, 1, 0, 0);
    checks++;
    if (regs1[255:224] !== 32'h8000_0001) begin
      errors++; $display("FAIL wide_reg7: got %h exp 80000001", regs1[255:224]);
    end
    wr(32'h120, 32'h1111_1111, 4'hF, 0, 0, 0);
    wr(32'h0FC, 32'h2222_2222, 4'hF, 0, 0, 0);
    wr(32'h100, 32'h7FFF_FFFF, 4'b1000, 0, 0, 0);
    sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0; awaddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 8; i++) begin m0[i%4] = '0; m1[i] = '0; end
    test_reset();
    test_same_cycle();
    test_w_lead_pulse();
    test_strobes();
    test_miss();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
